// File: rtl/approx_adder_pkg.sv
// Shared types and helpers for the pipelined approximate adder.
// Stage records are sized for the largest supported width; each instance
// only uses the low WIDTH bits of the operand and sum fields.
package approx_adder_pkg;

   localparam int unsigned MAX_WIDTH = 64;
   // Enough bits to hold any approx_bits value up to MAX_WIDTH.
   localparam int unsigned AB_W      = 7;

   typedef struct packed {
      logic                 valid;
      logic [AB_W-1:0]      approx_bits;
      logic                 carry;
      logic [MAX_WIDTH-1:0] a;
      logic [MAX_WIDTH-1:0] b;
      logic [MAX_WIDTH-1:0] psum;
   } stage_t;

   // Requests above the operand width mean "everything approximate".
   function automatic logic [AB_W-1:0] clamp_approx(input logic [AB_W-1:0] ab,
                                                     input int unsigned   width);
      if (32'(ab) > width) begin
         return AB_W'(width);
      end
      return ab;
   endfunction

   function automatic int unsigned seg_width(input int unsigned width,
                                             input int unsigned stages);
      return width / stages;
   endfunction

endpackage

// File: rtl/approx_seg_adder.sv
// Combinational SEG-bit ripple segment. Bit positions whose absolute index
// is below approx_bits use the approximate cell (carry-in ignored).
module approx_seg_adder
   import approx_adder_pkg::*;
#(
   parameter int unsigned SEG = 4
) (
   input  logic [SEG-1:0]  a,
   input  logic [SEG-1:0]  b,
   input  logic            cin,
   input  logic [AB_W-1:0] base,
   input  logic [AB_W-1:0] approx_bits,
   output logic [SEG-1:0]  s,
   output logic            co
);

   logic carry;

   // Ripple through the segment, choosing the cell type per bit.
   always_comb begin
      s     = '0;
      carry = cin;
      for (int unsigned i = 0; i < SEG; i++) begin
         if (32'(base) + i < 32'(approx_bits)) begin
            s[i]  = a[i] ^ b[i];
            carry = a[i] & b[i];
         end else begin
            s[i]  = a[i] ^ b[i] ^ carry;
            carry = (a[i] & b[i]) | (a[i] & carry) | (b[i] & carry);
         end
      end
      co = carry;
   end

endmodule

// File: rtl/approx_pipe_adder.sv
// Pipelined ripple-carry adder with a run-time selectable approximate LSB
// region and a valid/ready handshake. Each stage adds one SEG-bit segment.
// Optional exact-result monitor: define APPROX_PIPE_ADDER_ERR_MON_EN.
module approx_pipe_adder
   import approx_adder_pkg::*;
#(
   parameter int unsigned WIDTH     = 8,
   parameter int unsigned STAGES    = 2,
   parameter int unsigned ERR_CNT_W = 16
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic                       in_valid,
   output logic                       in_ready,
   input  logic [WIDTH-1:0]           a,
   input  logic [WIDTH-1:0]           b,
   input  logic                       cin,
   input  logic [$clog2(WIDTH+1)-1:0] approx_bits,
   output logic                       out_valid,
   input  logic                       out_ready,
   output logic [WIDTH-1:0]           sum,
   output logic                       cout,
   output logic                       err_flag,
   output logic [ERR_CNT_W-1:0]       err_count
);

   localparam int unsigned SEG = seg_width(WIDTH, STAGES);

   logic            adv;
   logic [AB_W-1:0] ab_clamped;

   assign adv        = !out_valid || out_ready;
   // Reset clears the output stage, so the block is always ready in reset.
   assign in_ready   = adv || rst;
   assign ab_clamped = clamp_approx(AB_W'(approx_bits), WIDTH);

   for (genvar k = 0; k < STAGES; k++) begin : g_stage
      stage_t         src;
      stage_t         stage_d;
      stage_t         stage_q;
      logic [SEG-1:0] seg_a;
      logic [SEG-1:0] seg_b;
      logic [SEG-1:0] seg_s;
      logic           seg_co;
      logic           unused_stage;

      if (k == 0) begin : g_first
         // Stage 0 takes the beat straight from the ports.
         always_comb begin
            src             = '0;
            src.valid       = in_valid;
            src.approx_bits = ab_clamped;
            src.carry       = cin;
            src.a           = MAX_WIDTH'(a);
            src.b           = MAX_WIDTH'(b);
         end
      end else begin : g_rest
         assign src = g_stage[k-1].stage_q;
      end

      assign seg_a = src.a[k*SEG +: SEG];
      assign seg_b = src.b[k*SEG +: SEG];

      approx_seg_adder #(
         .SEG(SEG)
      ) u_seg (
         .a          (seg_a),
         .b          (seg_b),
         .cin        (src.carry),
         .base       (AB_W'(k * SEG)),
         .approx_bits(src.approx_bits),
         .s          (seg_s),
         .co         (seg_co)
      );

      // Forward the beat, replacing the carry and filling in this segment.
      always_comb begin
         stage_d                      = src;
         stage_d.carry                = seg_co;
         stage_d.psum[k*SEG +: SEG]   = seg_s;
      end

      // Stage register: whole pipe shifts together or holds on a stall.
      always_ff @(posedge clk) begin
         if (rst) begin
            stage_q <= '0;
         end else if (adv) begin
            stage_q <= stage_d;
         end
      end

      // Spent operand segments and padding above WIDTH are intentionally dropped.
      assign unused_stage = ^stage_q;
   end

   assign out_valid = g_stage[STAGES-1].stage_q.valid;
   assign sum       = g_stage[STAGES-1].stage_q.psum[WIDTH-1:0];
   assign cout      = g_stage[STAGES-1].stage_q.carry;

`ifdef APPROX_PIPE_ADDER_ERR_MON_EN
   logic [WIDTH:0]     exact_d;
   logic [WIDTH:0]     exact_q [STAGES];
   logic [ERR_CNT_W-1:0] err_count_d;
   logic [ERR_CNT_W-1:0] err_count_q;

   assign exact_d = (WIDTH+1)'(a) + (WIDTH+1)'(b) + (WIDTH+1)'(cin);

   // Exact reference travels alongside its beat.
   always_ff @(posedge clk) begin
      if (rst) begin
         for (int unsigned k = 0; k < STAGES; k++) begin
            exact_q[k] <= '0;
         end
      end else if (adv) begin
         exact_q[0] <= exact_d;
         for (int unsigned k = 1; k < STAGES; k++) begin
            exact_q[k] <= exact_q[k-1];
         end
      end
   end

   assign err_flag = out_valid && ({cout, sum} != exact_q[STAGES-1]);

   // Count mismatching results as they are handed off, saturating at all-ones.
   always_comb begin
      err_count_d = err_count_q;
      if (out_valid && out_ready && err_flag && (err_count_q != '1)) begin
         err_count_d = err_count_q + ERR_CNT_W'(1);
      end
   end

   // Mismatch counter register.
   always_ff @(posedge clk) begin
      if (rst) begin
         err_count_q <= '0;
      end else begin
         err_count_q <= err_count_d;
      end
   end

   assign err_count = err_count_q;
`else
   assign err_flag  = 1'b0;
   assign err_count = '0;
`endif

endmodule

// File: tb/tb_approx_pipe_adder.sv
// Directed bench for approx_pipe_adder (WIDTH=8, STAGES=2, ERR_CNT_W=2) with
// a scoreboard of expected results fed at input handshakes.
module tb_approx_pipe_adder;

`ifdef APPROX_PIPE_ADDER_ERR_MON_EN
   localparam bit MON = 1'b1;
`else
   localparam bit MON = 1'b0;
`endif

   typedef struct packed {
      logic [7:0] s;
      logic       c;
      logic       e;
   } exp_t;

   logic       clk = 1'b0;
   logic       rst;
   logic       in_valid;
   logic       in_ready;
   logic [7:0] a;
   logic [7:0] b;
   logic       cin;
   logic [3:0] approx_bits;
   logic       out_valid;
   logic       out_ready;
   logic [7:0] sum;
   logic       cout;
   logic       err_flag;
   logic [1:0] err_count;

   int   checks     = 0;
   int   errors     = 0;
   int   rx_count   = 0;
   int   exp_errcnt = 0;
   exp_t exp_q[$];
   exp_t ex;

   approx_pipe_adder #(
      .WIDTH    (8),
      .STAGES   (2),
      .ERR_CNT_W(2)
   ) dut (
      .clk        (clk),
      .rst        (rst),
      .in_valid   (in_valid),
      .in_ready   (in_ready),
      .a          (a),
      .b          (b),
      .cin        (cin),
      .approx_bits(approx_bits),
      .out_valid  (out_valid),
      .out_ready  (out_ready),
      .sum        (sum),
      .cout       (cout),
      .err_flag   (err_flag),
      .err_count  (err_count)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
      checks++;
      assert (obs === expv) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
      end
   endtask

   // Reference: approximate cells below the clamped boundary, exact above.
   function automatic exp_t model(input logic [7:0] x, input logic [7:0] y, input logic ci,
                                  input logic [3:0] ab);
      exp_t       r;
      int         n;
      logic       c;
      logic [8:0] exact;
      n = (int'(ab) > 8) ? 8 : int'(ab);
      c = ci;
      for (int i = 0; i < 8; i++) begin
         if (i < n) begin
            r.s[i] = x[i] ^ y[i];
            c      = x[i] & y[i];
         end else begin
            r.s[i] = x[i] ^ y[i] ^ c;
            c      = (x[i] & y[i]) | (x[i] & c) | (y[i] & c);
         end
      end
      r.c   = c;
      exact = {1'b0, x} + {1'b0, y} + {8'b0, ci};
      r.e   = ({r.c, r.s} != exact);
      return r;
   endfunction

   // Scoreboard: pop/compare on output handshakes, push on input handshakes.
   always @(negedge clk) begin
      if (rst) begin
         exp_q.delete();
         exp_errcnt = 0;
      end else begin
         if (out_valid && out_ready) begin
            if (exp_q.size() == 0) begin
               check("spurious_out", 32'(out_valid), 32'd0);
            end else begin
               ex = exp_q.pop_front();
               check("sb_sum", 32'(sum), 32'(ex.s));
               check("sb_cout", 32'(cout), 32'(ex.c));
               check("sb_err_flag", 32'(err_flag), 32'(ex.e & MON));
               check("sb_err_count", 32'(err_count), 32'(exp_errcnt));
               rx_count++;
               if (MON && ex.e && exp_errcnt < 3) exp_errcnt++;
            end
         end
         if (in_valid && in_ready) exp_q.push_back(model(a, b, cin, approx_bits));
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic drive(input logic v, input logic [7:0] ta, input logic [7:0] tb,
                        input logic tc, input logic [3:0] tab);
      in_valid    = v;
      a           = ta;
      b           = tb;
      cin         = tc;
      approx_bits = tab;
   endtask

   // One isolated beat: check exact latency and the result fields directly.
   task automatic single(input string tag, input logic [7:0] ta, input logic [7:0] tb,
                         input logic tc, input logic [3:0] tab, input logic [7:0] es,
                         input logic ec, input logic ee);
      drive(1'b1, ta, tb, tc, tab);
      tick();
      in_valid = 1'b0;
      @(negedge clk);
      check({tag, "_early_valid"}, 32'(out_valid), 32'd0);
      tick();
      @(negedge clk);
      check({tag, "_valid"}, 32'(out_valid), 32'd1);
      check({tag, "_sum"}, 32'(sum), 32'(es));
      check({tag, "_cout"}, 32'(cout), 32'(ec));
      check({tag, "_err_flag"}, 32'(err_flag), 32'(ee & MON));
      tick();
   endtask

   initial begin
      rst       = 1'b1;
      out_ready = 1'b1;
      drive(1'b0, 8'h00, 8'h00, 1'b0, 4'd0);
      tick();
      @(negedge clk);
      check("rst_in_ready", 32'(in_ready), 32'd1);
      tick();
      rst = 1'b0;
      @(negedge clk);
      check("rst_out_valid", 32'(out_valid), 32'd0);
      check("rst_sum", 32'(sum), 32'd0);
      check("rst_cout", 32'(cout), 32'd0);
      check("rst_err_flag", 32'(err_flag), 32'd0);
      check("rst_err_count", 32'(err_count), 32'd0);

      single("exact", 8'h0F, 8'h01, 1'b0, 4'd0, 8'h10, 1'b0, 1'b0);
      single("approx2", 8'h0F, 8'h01, 1'b0, 4'd2, 8'h0E, 1'b0, 1'b1);
      @(negedge clk);
      check("approx2_err_count", 32'(err_count), MON ? 32'd1 : 32'd0);
      single("approx8", 8'hFF, 8'h01, 1'b1, 4'd8, 8'hFE, 1'b0, 1'b1);
      single("clamp15", 8'hFF, 8'h01, 1'b1, 4'd15, 8'hFE, 1'b0, 1'b1);
      single("exact_cin", 8'hFF, 8'h01, 1'b1, 4'd0, 8'h01, 1'b1, 1'b0);

      // Back-to-back beats with a four-cycle downstream stall.
      drive(1'b1, 8'h01, 8'h01, 1'b0, 4'd0);
      tick();
      drive(1'b1, 8'h02, 8'h02, 1'b0, 4'd0);
      tick();
      drive(1'b1, 8'h03, 8'h03, 1'b0, 4'd0);
      tick();
      out_ready = 1'b0;
      drive(1'b1, 8'h10, 8'h10, 1'b0, 4'd0);
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         check("stall_in_ready", 32'(in_ready), 32'd0);
         check("stall_valid", 32'(out_valid), 32'd1);
         check("stall_sum", 32'(sum), 32'h04);
         tick();
      end
      out_ready = 1'b1;
      tick();
      in_valid = 1'b0;
      repeat (4) tick();

      // Reset with both stages occupied: nothing from them may emerge.
      drive(1'b1, 8'h11, 8'h11, 1'b0, 4'd0);
      tick();
      drive(1'b1, 8'h22, 8'h22, 1'b0, 4'd3);
      tick();
      rst      = 1'b1;
      in_valid = 1'b0;
      tick();
      @(negedge clk);
      check("midrst_out_valid", 32'(out_valid), 32'd0);
      check("midrst_err_count", 32'(err_count), 32'd0);
      rst = 1'b0;
      for (int i = 0; i < 4; i++) begin
         tick();
         @(negedge clk);
         check("midrst_no_stale", 32'(out_valid), 32'd0);
      end

      // Four mismatching beats: a 2-bit counter must stick at 3.
      for (int i = 0; i < 4; i++) begin
         drive(1'b1, 8'h0F, 8'h01, 1'b0, 4'd2);
         tick();
      end
      in_valid = 1'b0;
      repeat (4) tick();
      @(negedge clk);
      check("sat_err_count", 32'(err_count), MON ? 32'd3 : 32'd0);

      check("rx_count", 32'(rx_count), 32'd13);
      check("sb_empty", 32'(exp_q.size()), 32'd0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
